// File: rtl/ucore_port_responder.sv
// Four-phase request/acknowledge responder with wait states and a small register file.
// Define UCORE_RESP_ERR_EN to flag out-of-range accesses on rsp_err.
module ucore_port_responder #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_ack,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       txn_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RELEASE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t state_q, state_d;

  logic [3:0]        cnt_q;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic [15:0]       txn_q;
  logic              capture;
  logic              ack_entry;
  logic              ack_exit;

  assign capture   = (state_q == S_IDLE) && req_valid;
  assign ack_entry = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign ack_exit  = (state_q == S_ACK) && !req_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (req_valid) state_d = S_WAIT;
      S_WAIT:    if (cnt_q == 4'd0) state_d = S_ACK;
      S_ACK:     if (!req_valid) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Entries beyond DEPTH do not exist, so out-of-range reads fall through to 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cap_addr == ADDR_W'(i)) rd_word = mem[i];
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_q     <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (capture) begin
      cnt_q     <= WAIT_INIT;
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ack_entry && cap_write) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cap_addr == ADDR_W'(i)) mem[i] <= cap_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      txn_q   <= '0;
    end else begin
      if (ack_entry) begin
        ack_q <= 1'b1;
        if (!cap_write) rdata_q <= rd_word;
      end
      if (ack_exit) begin
        ack_q <= 1'b0;
        txn_q <= txn_q + 16'd1;
      end
    end
  end

`ifdef UCORE_RESP_ERR_EN
  logic in_range;
  logic err_q;

  assign in_range = {1'b0, cap_addr} < (ADDR_W+1)'(DEPTH);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      err_q <= 1'b0;
    end else if (ack_entry) begin
      err_q <= !in_range;
    end else if (ack_exit) begin
      err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_ack   = ack_q;
  assign rsp_rdata = rdata_q;
  assign txn_count = txn_q;

endmodule
